// File: rtl/pixel_sink_writer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pixel_sink_writer_pkg
// Brief    : Shared constants for the pixel sink: FSM state encoding and the
//            default pixel width / frame geometry common with the filter core.
// Revision : 1.0 - initial release
// ============================================================================
package pixel_sink_writer_pkg;

  // Default geometry shared with the filter main module
  localparam int c_def_width = 8;
  localparam int c_def_img_w = 64;
  localparam int c_def_img_h = 64;

  // Capture FSM encoding
  localparam int c_state_w = 2;
  typedef logic [c_state_w-1:0] state_t;

  localparam state_t c_st_idle  = 2'd0;
  localparam state_t c_st_run   = 2'd1;
  localparam state_t c_st_drain = 2'd2;
  localparam state_t c_st_done  = 2'd3;

  // Number of pixels in one frame
  function automatic int frame_pixels(input int w, input int h);
    return w * h;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pixel_sink_writer_pix_fifo.sv
`default_nettype none
// ============================================================================
// Module   : pix_fifo
// Brief    : Small synchronous skid FIFO between the pixel stream and the
//            memory write port. Extra-bit pointers give exact full/empty.
// Revision : 1.0 - initial release
// ============================================================================
module pix_fifo #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int c_aw = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [c_aw:0]    r_wr_ptr;
  logic [c_aw:0]    r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Full blocks a push even when a pop happens in the same cycle
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // Flags and head-of-queue read
  always_comb begin
    empty = (r_wr_ptr == r_rd_ptr);
    full  = (r_wr_ptr[c_aw] != r_rd_ptr[c_aw]) &&
            (r_wr_ptr[c_aw-1:0] == r_rd_ptr[c_aw-1:0]);
    dout  = r_mem[r_rd_ptr[c_aw-1:0]];
  end

  // Pointer update; clear takes priority so a new frame starts empty
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (c_aw+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
    end
  end

  // Storage write; contents are don't-care while empty so no reset needed
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_aw-1:0]] <= din;
  end

endmodule
`default_nettype wire

// File: rtl/pixel_sink_writer.sv
`default_nettype none
// ============================================================================
// Module   : pixel_sink_writer
// Brief    : Captures one frame of filtered pixels per start request and
//            writes them to linear memory addresses through a skid FIFO.
//            endF is raised once every pixel of the frame has been written.
// Revision : 1.0 - initial release
// ============================================================================
module pixel_sink_writer
  import pixel_sink_writer_pkg::*;
#(
  parameter int WIDTH      = c_def_width,
  parameter int IMG_W      = c_def_img_w,
  parameter int IMG_H      = c_def_img_h,
  parameter int ADDR_W     = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              s_valid,
  input  logic [WIDTH-1:0]  s_data,
  output logic              s_ready,
  input  logic              m_busy,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [WIDTH-1:0]  m_wdata,
  output logic              endF
);

  localparam int                c_pixels    = frame_pixels(IMG_W, IMG_H);
  localparam logic [ADDR_W:0]   c_total     = (ADDR_W+1)'(c_pixels);
  localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(c_pixels - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_acc;
  logic [ADDR_W-1:0] r_addr;
  logic              w_start_ok;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [WIDTH-1:0]  w_fifo_head;

  // A start is honoured only between frames; mid-frame requests are dropped
  assign w_start_ok = start && ((r_state == c_st_idle) || (r_state == c_st_done));
  assign w_push     = s_valid && s_ready;
  assign w_pop      = m_we;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= c_st_idle;
    else      r_state <= w_state_nxt;
  end

  // Next-state: capture a whole frame, drain the FIFO, then report done
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_idle:  if (start) w_state_nxt = c_st_run;
      c_st_run:   if (r_acc == c_total) w_state_nxt = c_st_drain;
      c_st_drain: if (w_fifo_empty) w_state_nxt = c_st_done;
      c_st_done:  if (start) w_state_nxt = c_st_run;
      default:    w_state_nxt = c_st_idle;
    endcase
  end

  // Outputs: ready depends only on registered state, never on the same-cycle pop
  always_comb begin
    s_ready = (r_state == c_st_run) && !w_fifo_full && (r_acc < c_total);
    m_we    = !w_fifo_empty && !m_busy;
    m_wdata = w_fifo_empty ? '0 : w_fifo_head;
    m_addr  = r_addr;
    endF    = (r_state == c_st_done);
  end

  // Accept and address counters; the address holds at the last pixel so it never wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc  <= '0;
      r_addr <= '0;
    end else if (w_start_ok) begin
      r_acc  <= '0;
      r_addr <= '0;
    end else begin
      if (w_push) r_acc <= r_acc + (ADDR_W+1)'(1);
      if (w_pop && (r_addr != c_last_addr)) r_addr <= r_addr + ADDR_W'(1);
    end
  end

  pix_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (w_start_ok),
    .push  (w_push),
    .din   (s_data),
    .pop   (w_pop),
    .dout  (w_fifo_head),
    .full  (w_fifo_full),
    .empty (w_fifo_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_pixel_sink_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pixel_sink_writer
// Brief    : Self-checking bench for pixel_sink_writer on a 4x2 frame with a
//            four-entry FIFO. A frame-level reference model (pixel queue plus
//            accepted/written counts) predicts ready, write strobe, address,
//            data and the frame-complete flag every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pixel_sink_writer;

  localparam int WIDTH      = 8;
  localparam int IMG_W      = 4;
  localparam int IMG_H      = 2;
  localparam int ADDR_W     = 12;
  localparam int FIFO_DEPTH = 4;
  localparam int NPIX       = IMG_W * IMG_H;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              start = 1'b0;
  logic              s_valid = 1'b0;
  logic [WIDTH-1:0]  s_data = '0;
  logic              s_ready;
  logic              m_busy = 1'b0;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [WIDTH-1:0]  m_wdata;
  logic              endF;

  int n_tests = 0;
  int n_fail  = 0;

  pixel_sink_writer #(
    .WIDTH(WIDTH), .IMG_W(IMG_W), .IMG_H(IMG_H),
    .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_busy(m_busy), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .endF(endF)
  );

  always #5 clk = ~clk;

  // Reference model: a frame is a list of accepted pixels; write k goes to
  // address k with the k-th accepted pixel. Occupancy = accepted - written.
  bit             in_frame = 1'b0;
  bit             end_seen = 1'b0;
  int             acc = 0;
  int             wr = 0;
  int             done_wait = 0;
  bit             exp_ready;
  bit             exp_we;
  logic [WIDTH-1:0] pix_q[$];

  // Log of every observed memory write address
  logic [ADDR_W-1:0] waddr_q[$];

  always @(negedge clk) begin
    if (rst && m_we) waddr_q.push_back(m_addr);
  end

  // Per-cycle scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      in_frame  = 1'b0;
      end_seen  = 1'b0;
      acc       = 0;
      wr        = 0;
      done_wait = 0;
      pix_q.delete();
    end else begin
      exp_ready = in_frame && (acc < NPIX) && ((acc - wr) < FIFO_DEPTH);
      exp_we    = ((acc - wr) > 0) && !m_busy;
      n_tests++;
      if (s_ready !== exp_ready) begin
        n_fail++;
        $display("FAIL s_ready t=%0t got %b want %b", $time, s_ready, exp_ready);
      end
      n_tests++;
      if (m_we !== exp_we) begin
        n_fail++;
        $display("FAIL m_we t=%0t got %b want %b", $time, m_we, exp_we);
      end
      if (exp_we) begin
        n_tests++;
        if (m_addr !== ADDR_W'(wr)) begin
          n_fail++;
          $display("FAIL m_addr t=%0t got %0d want %0d", $time, m_addr, wr);
        end
        n_tests++;
        if (m_wdata !== pix_q[0]) begin
          n_fail++;
          $display("FAIL m_wdata t=%0t got %h want %h", $time, m_wdata, pix_q[0]);
        end
      end
      // endF: low until every pixel is written, then high within two cycles and held
      if (!(in_frame && wr == NPIX)) begin
        n_tests++;
        if (endF !== 1'b0) begin
          n_fail++;
          $display("FAIL endF_early t=%0t got %b want 0", $time, endF);
        end
      end else if (!end_seen) begin
        done_wait++;
        if (endF === 1'b1) end_seen = 1'b1;
        else if (done_wait > 2) begin
          n_tests++;
          n_fail++;
          end_seen = 1'b1;
          $display("FAIL endF_late t=%0t got %b want 1", $time, endF);
        end
      end else begin
        n_tests++;
        if (endF !== 1'b1) begin
          n_fail++;
          $display("FAIL endF_hold t=%0t got %b want 1", $time, endF);
        end
      end
      // Advance the model by what happens on the coming rising edge
      if (s_valid && exp_ready) begin
        pix_q.push_back(s_data);
        acc++;
      end
      if (exp_we) begin
        void'(pix_q.pop_front());
        wr++;
      end
      if (start && (!in_frame || end_seen)) begin
        in_frame  = 1'b1;
        end_seen  = 1'b0;
        acc       = 0;
        wr        = 0;
        done_wait = 0;
        pix_q.delete();
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Stream one frame. mode 0: steady, 1: six busy cycles, 2: random valid/busy/data
  task automatic send_frame(input int mode, input logic [WIDTH-1:0] base, input int start_at);
    int  sent = 0;
    int  cyc = 0;
    bit  rdy;
    while (sent < NPIX && cyc < 300) begin
      s_valid = (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = (mode == 2) ? WIDTH'($urandom) : WIDTH'(base + sent);
      m_busy  = (mode == 1) ? (cyc >= 2 && cyc < 8) :
                (mode == 2) ? ($urandom_range(0, 2) == 0) : 1'b0;
      start   = (cyc == start_at);
      #1;
      rdy = s_ready;
      if (mode == 1 && cyc == 7) begin
        n_tests++;
        if (s_ready !== 1'b0 || m_we !== 1'b0) begin
          n_fail++;
          $display("FAIL busy_full got ready=%b we=%b want ready=0 we=0", s_ready, m_we);
        end
      end
      @(posedge clk); #1;
      if (s_valid && rdy) sent++;
      cyc++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    m_busy  = 1'b0;
    n_tests++;
    if (sent != NPIX) begin
      n_fail++;
      $display("FAIL frame_accept got %0d pixels want %0d", sent, NPIX);
    end
  endtask

  task automatic wait_end();
    int c = 0;
    while (endF !== 1'b1 && c < 30) begin
      @(posedge clk); #1;
      c++;
    end
    n_tests++;
    if (endF !== 1'b1) begin
      n_fail++;
      $display("FAIL endF_timeout got %b want 1", endF);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if ({s_ready, m_we, m_addr, m_wdata, endF} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs got rdy=%b we=%b addr=%0d data=%h endF=%b want all 0",
               s_ready, m_we, m_addr, m_wdata, endF);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_valid_before_start();
    s_valid = 1'b1;
    s_data  = 8'hAA;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (s_ready !== 1'b0 || m_we !== 1'b0 || endF !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_valid got rdy=%b we=%b endF=%b want 0 0 0", s_ready, m_we, endF);
      end
    end
    s_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    int base;
    base = waddr_q.size();
    pulse_start();
    send_frame(0, 8'h10, -1);
    n_tests++;
    if (s_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL ready_after_last got %b want 0", s_ready);
    end
    wait_end();
    n_tests++;
    if (waddr_q.size() - base != NPIX || waddr_q[waddr_q.size()-1] !== ADDR_W'(NPIX-1)) begin
      n_fail++;
      $display("FAIL b2b_writes got %0d writes want %0d", waddr_q.size() - base, NPIX);
    end
  endtask

  task automatic test_busy();
    pulse_start();
    send_frame(1, 8'h40, -1);
    wait_end();
  endtask

  task automatic test_restart_done();
    int base;
    base = waddr_q.size();
    pulse_start();
    n_tests++;
    if (endF !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_endF got %b want 0", endF);
    end
    send_frame(0, 8'h20, -1);
    wait_end();
    n_tests++;
    if (waddr_q.size() - base != NPIX || waddr_q[base] !== '0) begin
      n_fail++;
      $display("FAIL restart_addr got %0d writes want %0d from addr 0", waddr_q.size() - base, NPIX);
    end
  endtask

  task automatic test_start_in_run();
    int base;
    base = waddr_q.size();
    pulse_start();
    send_frame(0, 8'h70, 3);
    wait_end();
    n_tests++;
    if (waddr_q.size() - base != NPIX || waddr_q[waddr_q.size()-1] !== ADDR_W'(NPIX-1)) begin
      n_fail++;
      $display("FAIL start_in_run got %0d writes want %0d", waddr_q.size() - base, NPIX);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    pulse_start();
    m_busy  = 1'b1;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_data = WIDTH'(8'h50 + i);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    n_tests++;
    if ({s_ready, m_we, m_addr, m_wdata, endF} !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs got rdy=%b we=%b addr=%0d data=%h endF=%b want all 0",
               s_ready, m_we, m_addr, m_wdata, endF);
    end
    m_busy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (s_ready !== 1'b0 || m_we !== 1'b0) begin
        n_fail++;
        $display("FAIL post_reset_idle got rdy=%b we=%b want 0 0", s_ready, m_we);
      end
    end
    s_valid = 1'b0;
    base = waddr_q.size();
    pulse_start();
    send_frame(0, 8'h60, -1);
    wait_end();
    n_tests++;
    if (waddr_q.size() - base != NPIX || waddr_q[base] !== '0) begin
      n_fail++;
      $display("FAIL midreset_restart got %0d writes want %0d from addr 0", waddr_q.size() - base, NPIX);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 6; f++) begin
      pulse_start();
      send_frame(2, 8'h00, -1);
      wait_end();
    end
  endtask

  initial begin
    test_reset();
    test_valid_before_start();
    test_back_to_back();
    test_busy();
    test_restart_done();
    test_start_in_run();
    test_reset_mid();
    test_random();
    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
